// File: rtl/pipe_pkg.sv
// Shared constants, types and helpers for the pipeline
// handshake/flush controller.
package pipe_pkg;
  localparam int PC_W = 32;
  localparam int NSTG = 5;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    REDIR = 1'b1
  } redir_st_e;

  function automatic logic src_hit(
    input logic [4:0] rd,
    input logic [4:0] rj,
    input logic [4:0] rk,
    input logic       use_rj,
    input logic       use_rk
  );
    return (rd != 5'd0) &&
           ((use_rj && (rj == rd)) ||
            (use_rk && (rk == rd)));
  endfunction
endpackage

// File: rtl/pipe_ctrl_if.sv
// Control bundle between the pipeline controller and the
// stage datapaths / fetch unit.
interface pipe_ctrl_if;
  import pipe_pkg::*;

  logic            fs_inst_ok;
  logic            es_busy;
  logic            ms_busy;
  logic [4:0]      ds_rj;
  logic [4:0]      ds_rk;
  logic            ds_use_rj;
  logic            ds_use_rk;
  logic [4:0]      es_rd;
  logic            es_rf_we;
  logic            es_res_from_dram;
  logic            es_res_from_csr;
  logic [4:0]      ms_rd;
  logic            ms_rf_we;
  logic            ms_res_from_csr;
  logic            es_br_taken;
  logic [PC_W-1:0] es_br_target;
  logic            wb_ex;
  logic            wb_ertn;
  logic [PC_W-1:0] ex_entry;
  logic [PC_W-1:0] era;
  logic            redirect_ack;

  logic            ds_reg_en;
  logic            es_reg_en;
  logic            ms_reg_en;
  logic            wb_reg_en;
  logic            fs_valid;
  logic            ds_valid;
  logic            es_valid;
  logic            ms_valid;
  logic            wb_valid;
  logic            pipe_flush;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic [31:0]     stall_cnt;

  modport master (
    input  fs_inst_ok, es_busy, ms_busy,
    input  ds_rj, ds_rk, ds_use_rj, ds_use_rk,
    input  es_rd, es_rf_we, es_res_from_dram,
    input  es_res_from_csr,
    input  ms_rd, ms_rf_we, ms_res_from_csr,
    input  es_br_taken, es_br_target,
    input  wb_ex, wb_ertn, ex_entry, era,
    input  redirect_ack,
    output ds_reg_en, es_reg_en, ms_reg_en,
    output wb_reg_en,
    output fs_valid, ds_valid, es_valid,
    output ms_valid, wb_valid,
    output pipe_flush, redirect_valid,
    output redirect_pc, stall_cnt
  );

  modport slave (
    output fs_inst_ok, es_busy, ms_busy,
    output ds_rj, ds_rk, ds_use_rj, ds_use_rk,
    output es_rd, es_rf_we, es_res_from_dram,
    output es_res_from_csr,
    output ms_rd, ms_rf_we, ms_res_from_csr,
    output es_br_taken, es_br_target,
    output wb_ex, wb_ertn, ex_entry, era,
    output redirect_ack,
    input  ds_reg_en, es_reg_en, ms_reg_en,
    input  wb_reg_en,
    input  fs_valid, ds_valid, es_valid,
    input  ms_valid, wb_valid,
    input  pipe_flush, redirect_valid,
    input  redirect_pc, stall_cnt
  );
endinterface

// File: rtl/hazard_det.sv
// ID-stage hazard comparator: stalls only on producers whose
// result cannot yet be forwarded (loads/CSR in EX, CSR in MEM).
module hazard_det
  import pipe_pkg::*;
(
  input  logic [4:0] ds_rj,
  input  logic [4:0] ds_rk,
  input  logic       ds_use_rj,
  input  logic       ds_use_rk,
  input  logic       es_valid,
  input  logic       es_rf_we,
  input  logic       es_res_from_dram,
  input  logic       es_res_from_csr,
  input  logic [4:0] es_rd,
  input  logic       ms_valid,
  input  logic       ms_rf_we,
  input  logic       ms_res_from_csr,
  input  logic [4:0] ms_rd,
  output logic       hazard
);
  logic es_src;
  logic ms_src;

  assign es_src = es_valid & es_rf_we &
                  (es_res_from_dram | es_res_from_csr);
  assign ms_src = ms_valid & ms_rf_we & ms_res_from_csr;

  assign hazard =
    (es_src & src_hit(es_rd, ds_rj, ds_rk,
                      ds_use_rj, ds_use_rk)) |
    (ms_src & src_hit(ms_rd, ds_rj, ds_rk,
                      ds_use_rj, ds_use_rk));
endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage valid/allowin chain, flush control and
// redirect hold FSM.
module pipe_ctrl
  import pipe_pkg::*;
(
  input logic         clk,
  input logic         rst,
  pipe_ctrl_if.master bus
);
  logic [NSTG-1:0]       v_q;
  logic [STG_MEM:STG_IF] rgo;
  logic [STG_WB:STG_ID]  alw;
  logic                  hazard;
  logic                  wb_flush;
  logic                  br_flush;
  logic                  any_flush;
  logic [PC_W-1:0]       wb_tgt;
  logic [PC_W-1:0]       flush_tgt;
  logic [PC_W-1:0]       pc_q;
  logic [PC_W-1:0]       pc_d;
  logic [PC_W-1:0]       rd_pc;
  logic                  rd_vld;
  redir_st_e             st_q;
  redir_st_e             st_d;
  logic [31:0]           stall_q;

  hazard_det u_hz (
    .ds_rj           (bus.ds_rj),
    .ds_rk           (bus.ds_rk),
    .ds_use_rj       (bus.ds_use_rj),
    .ds_use_rk       (bus.ds_use_rk),
    .es_valid        (v_q[STG_EX]),
    .es_rf_we        (bus.es_rf_we),
    .es_res_from_dram(bus.es_res_from_dram),
    .es_res_from_csr (bus.es_res_from_csr),
    .es_rd           (bus.es_rd),
    .ms_valid        (v_q[STG_MEM]),
    .ms_rf_we        (bus.ms_rf_we),
    .ms_res_from_csr (bus.ms_res_from_csr),
    .ms_rd           (bus.ms_rd),
    .hazard          (hazard)
  );

  always_comb begin
    rgo          = '0;
    alw          = '0;
    rgo[STG_IF]  = v_q[STG_IF] & bus.fs_inst_ok;
    rgo[STG_ID]  = v_q[STG_ID] & ~hazard;
    rgo[STG_EX]  = v_q[STG_EX] & ~bus.es_busy;
    rgo[STG_MEM] = v_q[STG_MEM] & ~bus.ms_busy;
    alw[STG_WB]  = 1'b1;
    alw[STG_MEM] = ~v_q[STG_MEM] |
                   (rgo[STG_MEM] & alw[STG_WB]);
    alw[STG_EX]  = ~v_q[STG_EX] |
                   (rgo[STG_EX] & alw[STG_MEM]);
    alw[STG_ID]  = ~v_q[STG_ID] |
                   (rgo[STG_ID] & alw[STG_EX]);
  end

  // ertn wins over an exception; WB beats an EX branch
  assign wb_flush  = v_q[STG_WB] & (bus.wb_ex | bus.wb_ertn);
  assign br_flush  = rgo[STG_EX] & bus.es_br_taken & ~wb_flush;
  assign any_flush = wb_flush | br_flush;
  assign wb_tgt    = bus.wb_ertn ? bus.era : bus.ex_entry;
  assign flush_tgt = wb_flush ? wb_tgt : bus.es_br_target;

  always_comb begin
    st_d   = st_q;
    pc_d   = pc_q;
    rd_vld = 1'b0;
    rd_pc  = pc_q;
    unique case (st_q)
      IDLE: begin
        if (any_flush) begin
          rd_vld = 1'b1;
          rd_pc  = flush_tgt;
          if (!bus.redirect_ack) begin
            st_d = REDIR;
            pc_d = flush_tgt;
          end
        end
      end
      REDIR: begin
        rd_vld = 1'b1;
        if (wb_flush) begin
          pc_d  = wb_tgt;
          rd_pc = wb_tgt;
        end
        if (bus.redirect_ack) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= '0;
      st_q    <= IDLE;
      pc_q    <= '0;
      stall_q <= '0;
    end else begin
      st_q <= st_d;
      pc_q <= pc_d;
      v_q[STG_IF] <= ~any_flush & (st_q == IDLE);
      if (any_flush)        v_q[STG_ID] <= 1'b0;
      else if (alw[STG_ID]) v_q[STG_ID] <= rgo[STG_IF];
      if (wb_flush)         v_q[STG_EX] <= 1'b0;
      else if (alw[STG_EX]) v_q[STG_EX] <= rgo[STG_ID];
      if (wb_flush)          v_q[STG_MEM] <= 1'b0;
      else if (alw[STG_MEM]) v_q[STG_MEM] <= rgo[STG_EX];
      if (wb_flush)         v_q[STG_WB] <= 1'b0;
      else if (alw[STG_WB]) v_q[STG_WB] <= rgo[STG_MEM];
      if (v_q[STG_ID] & hazard) stall_q <= stall_q + 32'd1;
    end
  end

  assign bus.ds_reg_en      = rgo[STG_IF] & alw[STG_ID];
  assign bus.es_reg_en      = rgo[STG_ID] & alw[STG_EX];
  assign bus.ms_reg_en      = rgo[STG_EX] & alw[STG_MEM];
  assign bus.wb_reg_en      = rgo[STG_MEM] & alw[STG_WB];
  assign bus.fs_valid       = v_q[STG_IF];
  assign bus.ds_valid       = v_q[STG_ID];
  assign bus.es_valid       = v_q[STG_EX];
  assign bus.ms_valid       = v_q[STG_MEM];
  assign bus.wb_valid       = v_q[STG_WB];
  assign bus.pipe_flush     = wb_flush;
  assign bus.redirect_valid = rd_vld;
  assign bus.redirect_pc    = rd_pc;
  assign bus.stall_cnt      = stall_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: occupancy-array reference model
// checked every cycle, plus hand-computed scenario checks.
module tb_pipe_ctrl;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  pipe_ctrl_if ifc ();

  pipe_ctrl dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference model: occupancy bits per stage, pending redirect
  bit          mv [5];
  bit          rg [5];
  bit          al [5];
  bit          nv [5];
  bit          mpend;
  logic [31:0] mpc;
  logic [31:0] mcnt;
  bit          haz;
  bit          wbf;
  bit          brf;
  bit          rv;
  logic [31:0] wtgt;
  logic [31:0] tgt;
  logic [31:0] epc;

  function automatic bit dep(input logic [4:0] rd);
    return rd != 5'd0 &&
      ((ifc.ds_use_rj && ifc.ds_rj == rd) ||
       (ifc.ds_use_rk && ifc.ds_rk == rd));
  endfunction

  initial begin
    for (int i = 0; i < 5; i++) mv[i] = 0;
    mpend = 0;
    mpc   = 0;
    mcnt  = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      #4;
      haz = (mv[2] && ifc.es_rf_we &&
             (ifc.es_res_from_dram || ifc.es_res_from_csr) &&
             dep(ifc.es_rd)) ||
            (mv[3] && ifc.ms_rf_we && ifc.ms_res_from_csr &&
             dep(ifc.ms_rd));
      rg[0] = mv[0] && ifc.fs_inst_ok;
      rg[1] = mv[1] && !haz;
      rg[2] = mv[2] && !ifc.es_busy;
      rg[3] = mv[3] && !ifc.ms_busy;
      rg[4] = mv[4];
      al[4] = 1;
      for (int s = 3; s >= 0; s--)
        al[s] = !mv[s] || (rg[s] && al[s+1]);
      wbf  = mv[4] && (ifc.wb_ex || ifc.wb_ertn);
      brf  = rg[2] && ifc.es_br_taken && !wbf;
      wtgt = ifc.wb_ertn ? ifc.era : ifc.ex_entry;
      tgt  = wbf ? wtgt : ifc.es_br_target;
      rv   = mpend || wbf || brf;
      epc  = mpend ? (wbf ? wtgt : mpc) : tgt;
      chk("ds_reg_en", ifc.ds_reg_en, rg[0] && al[1]);
      chk("es_reg_en", ifc.es_reg_en, rg[1] && al[2]);
      chk("ms_reg_en", ifc.ms_reg_en, rg[2] && al[3]);
      chk("wb_reg_en", ifc.wb_reg_en, rg[3]);
      chk("fs_valid", ifc.fs_valid, mv[0]);
      chk("ds_valid", ifc.ds_valid, mv[1]);
      chk("es_valid", ifc.es_valid, mv[2]);
      chk("ms_valid", ifc.ms_valid, mv[3]);
      chk("wb_valid", ifc.wb_valid, mv[4]);
      chk("pipe_flush", ifc.pipe_flush, wbf);
      chk("redirect_valid", ifc.redirect_valid, rv);
      if (rv) chk("redirect_pc", ifc.redirect_pc, epc);
      chk("stall_cnt", ifc.stall_cnt, mcnt);
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < 5; i++) mv[i] = 0;
        mpend = 0;
        mpc   = 0;
        mcnt  = 0;
      end else begin
        nv[0] = !(wbf || brf || mpend);
        nv[1] = (wbf || brf) ? 0 : (al[1] ? rg[0] : mv[1]);
        for (int s = 2; s < 5; s++)
          nv[s] = wbf ? 0 : (al[s] ? rg[s-1] : mv[s]);
        if (mv[1] && haz) mcnt = mcnt + 1;
        if (!mpend) begin
          if ((wbf || brf) && !ifc.redirect_ack) begin
            mpend = 1;
            mpc   = tgt;
          end
        end else begin
          if (wbf) mpc = wtgt;
          if (ifc.redirect_ack) mpend = 0;
        end
        for (int i = 0; i < 5; i++) mv[i] = nv[i];
      end
    end
  end

  task automatic go();
    @(negedge clk);
    ifc.fs_inst_ok       = 1;
    ifc.es_busy          = 0;
    ifc.ms_busy          = 0;
    ifc.ds_rj            = 0;
    ifc.ds_rk            = 0;
    ifc.ds_use_rj        = 0;
    ifc.ds_use_rk        = 0;
    ifc.es_rd            = 0;
    ifc.es_rf_we         = 0;
    ifc.es_res_from_dram = 0;
    ifc.es_res_from_csr  = 0;
    ifc.ms_rd            = 0;
    ifc.ms_rf_we         = 0;
    ifc.ms_res_from_csr  = 0;
    ifc.es_br_taken      = 0;
    ifc.wb_ex            = 0;
    ifc.wb_ertn          = 0;
    ifc.redirect_ack     = 0;
  endtask

  task automatic wait_full(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      go();
      #4;
      ok = ifc.fs_valid && ifc.ds_valid && ifc.es_valid &&
           ifc.ms_valid && ifc.wb_valid;
    end
    chk({nm, "_fill_timeout"}, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    rst              = 1;
    ifc.es_br_target = 32'h1c000200;
    ifc.ex_entry     = 32'h1c008000;
    ifc.era          = 32'h1c000100;
    go();
    go();
    rst = 0;
    #4;
    chk("rst_fs_valid", ifc.fs_valid, 0);
    chk("rst_wb_valid", ifc.wb_valid, 0);
    chk("rst_ds_reg_en", ifc.ds_reg_en, 0);
    chk("rst_redirect_valid", ifc.redirect_valid, 0);
    chk("rst_redirect_pc", ifc.redirect_pc, 0);
    chk("rst_pipe_flush", ifc.pipe_flush, 0);
    chk("rst_stall_cnt", ifc.stall_cnt, 0);

    for (int k = 1; k <= 8; k++) begin
      go();
      #4;
      if (k >= 5) begin
        chk("line_wb_valid", ifc.wb_valid, 1);
        chk("line_ds_reg_en", ifc.ds_reg_en, 1);
        chk("line_es_reg_en", ifc.es_reg_en, 1);
        chk("line_ms_reg_en", ifc.ms_reg_en, 1);
        chk("line_wb_reg_en", ifc.wb_reg_en, 1);
      end
    end
    chk("line_stall_cnt", ifc.stall_cnt, 0);

    go();
    ifc.es_rd            = 5;
    ifc.es_rf_we         = 1;
    ifc.es_res_from_dram = 1;
    ifc.ds_rj            = 5;
    ifc.ds_use_rj        = 1;
    #4;
    chk("lu_es_reg_en", ifc.es_reg_en, 0);
    chk("lu_ds_reg_en", ifc.ds_reg_en, 0);
    go();
    #4;
    chk("lu_es_bubble", ifc.es_valid, 0);
    chk("lu_stall_cnt", ifc.stall_cnt, 1);
    chk("lu_es_reg_en_after", ifc.es_reg_en, 1);

    wait_full("fwd");
    go();
    ifc.es_rd            = 0;
    ifc.es_rf_we         = 1;
    ifc.es_res_from_dram = 1;
    ifc.ds_use_rj        = 1;
    #4;
    chk("rd0_no_stall", ifc.es_reg_en, 1);
    go();
    ifc.es_rd     = 9;
    ifc.es_rf_we  = 1;
    ifc.ds_rk     = 9;
    ifc.ds_use_rk = 1;
    #4;
    chk("alu_fwd_no_stall", ifc.es_reg_en, 1);
    go();
    ifc.ms_rd           = 7;
    ifc.ms_rf_we        = 1;
    ifc.ms_res_from_csr = 1;
    ifc.ds_rk           = 7;
    ifc.ds_use_rk       = 1;
    #4;
    chk("mcsr_es_reg_en", ifc.es_reg_en, 0);
    go();
    #4;
    chk("mcsr_stall_cnt", ifc.stall_cnt, 2);

    wait_full("busy");
    for (int b = 1; b <= 4; b++) begin
      go();
      if (b <= 3) ifc.es_busy = 1;
      #4;
      if (b <= 3) begin
        chk("busy_ds_reg_en", ifc.ds_reg_en, 0);
        chk("busy_ds_valid", ifc.ds_valid, 1);
        chk("busy_es_valid", ifc.es_valid, 1);
      end
      if (b >= 2) chk("busy_ms_bubble", ifc.ms_valid, 0);
    end

    wait_full("br");
    go();
    ifc.es_br_taken = 1;
    ifc.redirect_ack = 1;
    #4;
    chk("br_redirect_pc", ifc.redirect_pc, 32'h1c000200);
    chk("br_pipe_flush", ifc.pipe_flush, 0);
    go();
    #4;
    chk("br_fs_clr", ifc.fs_valid, 0);
    chk("br_ds_clr", ifc.ds_valid, 0);
    chk("br_ms_keep", ifc.ms_valid, 1);
    chk("br_redirect_done", ifc.redirect_valid, 0);

    wait_full("exc");
    go();
    ifc.wb_ex = 1;
    #4;
    chk("exc_pipe_flush", ifc.pipe_flush, 1);
    chk("exc_redirect_pc", ifc.redirect_pc, 32'h1c008000);
    go();
    #4;
    chk("exc_fs_clr", ifc.fs_valid, 0);
    chk("exc_ms_clr", ifc.ms_valid, 0);
    chk("exc_wb_clr", ifc.wb_valid, 0);
    chk("exc_hold_valid", ifc.redirect_valid, 1);
    chk("exc_hold_pc", ifc.redirect_pc, 32'h1c008000);
    go();
    ifc.redirect_ack = 1;
    #4;
    chk("exc_ack_valid", ifc.redirect_valid, 1);
    chk("exc_ack_pc", ifc.redirect_pc, 32'h1c008000);
    go();
    #4;
    chk("exc_idle", ifc.redirect_valid, 0);

    wait_full("both");
    go();
    ifc.wb_ertn      = 1;
    ifc.es_br_taken  = 1;
    ifc.redirect_ack = 1;
    #4;
    chk("both_redirect_pc", ifc.redirect_pc, 32'h1c000100);
    chk("both_pipe_flush", ifc.pipe_flush, 1);
    go();
    #4;
    chk("both_ms_clr", ifc.ms_valid, 0);
    chk("both_es_clr", ifc.es_valid, 0);
    chk("both_ds_clr", ifc.ds_valid, 0);

    wait_full("rstr");
    go();
    ifc.wb_ex = 1;
    #4;
    go();
    rst = 1;
    #4;
    chk("rstr_in_redir", ifc.redirect_valid, 1);
    go();
    rst = 0;
    #4;
    chk("rstr_redirect_valid", ifc.redirect_valid, 0);
    chk("rstr_stall_cnt", ifc.stall_cnt, 0);
    chk("rstr_es_valid", ifc.es_valid, 0);
    chk("rstr_wb_valid", ifc.wb_valid, 0);
    go();
    #4;
    chk("rstr_fs_restart", ifc.fs_valid, 1);

    go();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
